// File: rtl/gemm_pkg.sv
// Shared types and constants for the 4x4 GEMM tile sequencer.
// Build option GEMM_SEQ_SAT_EN is consumed by gemm_mac.
package gemm_pkg;

    localparam int DW     = 32;
    localparam int N      = 4;
    localparam int B_BASE = 16;
    localparam int SRC_AW = 5;
    localparam int DST_AW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic signed [DW-1:0] word_t;

endpackage

// File: rtl/gemm_seq_if.sv
// Source-read and destination-write buses of the GEMM sequencer.
// master = sequencer side, slave = buffer side.
interface gemm_seq_if;
    import gemm_pkg::*;

    logic              exec;
    logic [SRC_AW-1:0] ia;
    word_t             d;
    logic              outr;
    logic [DST_AW-1:0] oa;
    word_t             result;

    modport master (
        output exec, ia, outr, oa, result,
        input  d
    );

    modport slave (
        input  exec, ia, outr, oa, result,
        output d
    );

endinterface

// File: rtl/gemm_mac.sv
// Operand latch, signed 32x32 multiplier and accumulator.
// GEMM_SEQ_SAT_EN selects saturating instead of wrapping accumulation.
module gemm_mac
    import gemm_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clr,
    input  logic  ld_a,
    input  logic  acc_en,
    input  word_t d,
    output word_t acc
);

    word_t                   r_a;
    word_t                   r_acc;
    logic signed [2*DW-1:0]  w_prod;
    word_t                   w_nxt;

    assign w_prod = 64'(r_a) * 64'(d);

`ifdef GEMM_SEQ_SAT_EN
    localparam logic signed [2*DW+1:0] SAT_MAX = 66'sh7FFF_FFFF;
    localparam logic signed [2*DW+1:0] SAT_MIN = -66'sh8000_0000;

    logic signed [2*DW+1:0] w_sum;

    assign w_sum = 66'(r_acc) + 66'(w_prod);

    always_comb begin
        w_nxt = word_t'(w_sum[DW-1:0]);
        if (w_sum > SAT_MAX)
            w_nxt = word_t'(SAT_MAX[DW-1:0]);
        else if (w_sum < SAT_MIN)
            w_nxt = word_t'(SAT_MIN[DW-1:0]);
    end
`else
    assign w_nxt = r_acc + word_t'(w_prod[DW-1:0]);
`endif

    // d is only sampled under ld_a/acc_en, so X elsewhere never lands in state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_acc <= '0;
        end else begin
            if (ld_a)
                r_a <= d;
            if (clr)
                r_acc <= '0;
            else if (acc_en)
                r_acc <= w_nxt;
        end
    end

    assign acc = r_acc;

endmodule

// File: rtl/gemm_seq.sv
// 4x4 GEMM tile sequencer: fetches A/B from the source buffer, writes C.
// Accumulation mode set by GEMM_SEQ_SAT_EN (see gemm_mac).
module gemm_seq
    import gemm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    gemm_seq_if.master bus
);

    state_t            r_state;
    logic [1:0]        r_i;
    logic [1:0]        r_j;
    logic [3:0]        r_phase;
    logic [SRC_AW-1:0] r_ia;
    logic [DST_AW-1:0] r_oa;
    word_t             r_result;

    logic              w_fetch;
    logic              w_write;
    logic              w_exec;
    logic              w_odd;
    logic              w_last;
    logic [1:0]        w_k;
    logic [SRC_AW-1:0] w_ia;
    logic              w_clr;
    logic              w_ld_a;
    logic              w_acc_en;
    word_t             w_acc;

    assign w_fetch = (r_state == FETCH);
    assign w_write = (r_state == WRITE);
    assign w_odd   = r_phase[0];
    assign w_k     = r_phase[2:1];
    assign w_exec  = w_fetch && !r_phase[3];
    assign w_last  = (r_i == 2'd3) && (r_j == 2'd3);

    assign w_ia = w_odd ? SRC_AW'(B_BASE) + {1'b0, w_k, r_j}
                        : {1'b0, r_i, w_k};

    // even phases 2..8 see B on d, with A already in r_a
    assign w_clr    = !w_fetch;
    assign w_ld_a   = w_fetch && w_odd;
    assign w_acc_en = w_fetch && !w_odd && (r_phase != 4'd0);

    gemm_mac u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_clr),
        .ld_a   (w_ld_a),
        .acc_en (w_acc_en),
        .d      (bus.d),
        .acc    (w_acc)
    );

    assign busy       = w_fetch || w_write;
    assign done       = (r_state == DONE);
    assign bus.exec   = w_exec;
    assign bus.ia     = w_exec ? w_ia : r_ia;
    assign bus.outr   = w_write;
    assign bus.oa     = w_write ? {r_i, r_j} : r_oa;
    assign bus.result = w_write ? w_acc : r_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_i      <= '0;
            r_j      <= '0;
            r_phase  <= '0;
            r_ia     <= '0;
            r_oa     <= '0;
            r_result <= '0;
        end else begin
            if (w_exec)
                r_ia <= w_ia;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= FETCH;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_phase <= '0;
                    end
                end
                FETCH: begin
                    if (r_phase == 4'd8) begin
                        r_phase <= '0;
                        r_state <= WRITE;
                    end else begin
                        r_phase <= r_phase + 4'd1;
                    end
                end
                WRITE: begin
                    r_oa     <= {r_i, r_j};
                    r_result <= w_acc;
                    r_j      <= r_j + 2'd1;
                    if (r_j == 2'd3)
                        r_i <= r_i + 2'd1;
                    r_state  <= w_last ? DONE : FETCH;
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gemm_seq.sv
// Bench for gemm_seq: source/destination buffer models plus a plain
// arithmetic reference for each C element (honours GEMM_SEQ_SAT_EN).
module tb_gemm_seq;
    import gemm_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic done;

    gemm_seq_if bus ();

    gemm_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [32];
    logic [31:0] dst [16];
    logic [31:0] expv [16];

    always @(posedge clk) if (bus.exec) bus.d <= mem[bus.ia];
    always @(posedge clk) if (bus.outr) dst[bus.oa] <= bus.result;

    int cyc = 0;
    int t0  = 0;
    int mt;
    always @(posedge clk) cyc <= cyc + 1;

    int          ev_t [$];
    logic [3:0]  ev_oa [$];
    logic [31:0] ev_r [$];
    int          done_t [$];
    logic [4:0]  ia_q [$];
    int          exec_n;
    logic        bh [400];
    int          starts [$];

    always @(negedge clk) begin
        mt = cyc - t0;
        if (bus.outr) begin
            ev_t.push_back(mt);
            ev_oa.push_back(bus.oa);
            ev_r.push_back(bus.result);
        end
        if (bus.exec) begin
            exec_n++;
            ia_q.push_back(bus.ia);
        end
        if (done) done_t.push_back(mt);
        if (mt >= 0 && mt < 400) bh[mt] = busy;
    end

    int ncmp = 0;
    int nbad = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_elem(input int i, input int j);
        longint s;
        longint p;
        logic signed [31:0] a;
        logic signed [31:0] b;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            a = mem[i*4+k];
            b = mem[16+k*4+j];
            p = longint'(a) * longint'(b);
            s += p;
`ifdef GEMM_SEQ_SAT_EN
            if (s > 64'sh7FFFFFFF) s = 64'sh7FFFFFFF;
            else if (s < -64'sh80000000) s = -64'sh80000000;
`endif
        end
        return s[31:0];
    endfunction

    task automatic load(input int kind);
        int v;
        for (int n = 0; n < 32; n++) begin
            case (kind)
                0: mem[n] = (n < 16) ? ((n/4 == n%4) ? 32'd1 : 32'd0)
                                     : 32'(n - 15);
                1: mem[n] = (n < 16) ? 32'd2 : 32'd3;
                2: mem[n] = 32'h7FFFFFFF;
                3: mem[n] = (n < 16) ? 32'hFFFFFFFF : 32'h7FFFFFFF;
                4: mem[n] = $urandom();
                default: begin
                    v = int'($urandom_range(0, 200)) - 100;
                    mem[n] = v;
                end
            endcase
        end
        for (int e = 0; e < 16; e++) begin
            expv[e] = ref_elem(e/4, e%4);
            dst[e]  = 32'hDEADBEEF;
        end
    endtask

    task automatic run(input int ncyc, input int rst_at);
        ev_t.delete(); ev_oa.delete(); ev_r.delete();
        done_t.delete(); ia_q.delete();
        exec_n = 0;
        t0 = cyc;
        for (int t = 0; t < ncyc; t++) begin
            start = 1'b0;
            foreach (starts[s]) if (starts[s] == t) start = 1'b1;
            if (t == rst_at) begin
                start = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                chk("async_reset_outs",
                    {busy, done, bus.exec, bus.ia, bus.outr, bus.oa,
                     bus.result}, 64'd0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_tile(input string nm, input int first,
                              input int base);
        for (int e = 0; e < 16; e++) begin
            if (first + e < ev_t.size()) begin
                chk({nm, "_oa"},  64'(ev_oa[first+e]), 64'(e));
                chk({nm, "_res"}, 64'(ev_r[first+e]),  64'(expv[e]));
                chk({nm, "_cyc"}, 64'(ev_t[first+e]),  64'(base + 10*(e+1)));
            end
        end
    endtask

    task automatic check_dst(input string nm, input int cnt);
        for (int e = 0; e < cnt; e++)
            chk({nm, "_dst"}, 64'(dst[e]), 64'(expv[e]));
    endtask

    logic [4:0]  ia_exp [8] = '{5'd0, 5'd16, 5'd1, 5'd20,
                                5'd2, 5'd24, 5'd3, 5'd28};
    logic [31:0] edge_exp;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outs", {busy, done, bus.exec, bus.ia, bus.outr,
                           bus.oa, bus.result}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // identity x (1..16), extra starts at 5 and 161, new tile at 162
        load(0);
        starts = '{0, 5, 161, 162};
        run(330, -1);
        chk("t1_outr_count", 64'(ev_t.size()), 64'd32);
        chk("t1_done_count", 64'(done_t.size()), 64'd2);
        if (done_t.size() > 0) chk("t1_done0", 64'(done_t[0]), 64'd161);
        if (done_t.size() > 1) chk("t1_done1", 64'(done_t[1]), 64'd323);
        chk("t1_busy1",   64'(bh[1]),   64'd1);
        chk("t1_busy5",   64'(bh[5]),   64'd1);
        chk("t1_busy160", 64'(bh[160]), 64'd1);
        chk("t1_busy161", 64'(bh[161]), 64'd0);
        chk("t1_busy162", 64'(bh[162]), 64'd0);
        chk("t1_busy163", 64'(bh[163]), 64'd1);
        check_tile("t1a", 0, 0);
        check_tile("t1b", 16, 162);
        check_dst("t1", 16);

        // all 2 x all 3
        load(1);
        starts = '{0};
        run(170, -1);
        chk("t2_exec_cycles", 64'(exec_n), 64'd128);
        for (int n = 0; n < 8; n++)
            if (n < ia_q.size()) chk("t2_ia_seq", 64'(ia_q[n]), 64'(ia_exp[n]));
        if (ev_r.size() > 0) chk("t2_res_const", 64'(ev_r[0]), 64'h18);
        check_tile("t2", 0, 0);
        check_dst("t2", 16);

        // max positive operands
        load(2);
        run(170, -1);
`ifdef GEMM_SEQ_SAT_EN
        edge_exp = 32'h7FFFFFFF;
`else
        edge_exp = 32'h00000004;
`endif
        if (ev_r.size() > 15) chk("t3_res_const", 64'(ev_r[15]), 64'(edge_exp));
        check_tile("t3", 0, 0);

        // -1 x max positive
        load(3);
        run(170, -1);
`ifdef GEMM_SEQ_SAT_EN
        edge_exp = 32'h80000000;
`else
        edge_exp = 32'h00000004;
`endif
        if (ev_r.size() > 15) chk("t4_res_const", 64'(ev_r[15]), 64'(edge_exp));
        check_tile("t4", 0, 0);

        // random full-range and small signed operands
        load(4);
        run(170, -1);
        chk("t5a_outr_count", 64'(ev_t.size()), 64'd16);
        check_tile("t5a", 0, 0);
        load(5);
        run(170, -1);
        check_tile("t5b", 0, 0);
        check_dst("t5b", 16);

        // reset mid element 3, partial results retained, then clean rerun
        load(4);
        run(60, 37);
        chk("t6_outr_before_rst", 64'(ev_t.size()), 64'd3);
        check_dst("t6_partial", 3);
        load(5);
        run(170, -1);
        chk("t6_done_count", 64'(done_t.size()), 64'd1);
        check_tile("t6b", 0, 0);
        check_dst("t6b", 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
